// File: rtl/seq_multiplier.sv
// Sequential radix-2 shift-add unsigned multiplier with a start/busy/done handshake.
// It produces one partial product per clock, so an operation takes WIDTH cycles.
module seq_multiplier #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] product_low,
   output logic [WIDTH-1:0] product_high
);

   localparam int unsigned CntW = $clog2(WIDTH);
   localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] prod_lo_q, prod_lo_d;
   logic [WIDTH-1:0] prod_hi_q, prod_hi_d;
   logic [CntW-1:0]  count_q, count_d;
   logic [WIDTH:0]   sum;
   logic             accept;

   always_comb begin
      // WIDTH+1-bit adder keeps the carry that is shifted into the accumulator
      sum       = {1'b0, acc_q} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
      accept    = start && (state_q != StRun);
      state_d   = state_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      acc_d     = acc_q;
      count_d   = count_q;
      prod_lo_d = prod_lo_q;
      prod_hi_d = prod_hi_q;
      unique case (state_q)
         StIdle, StDone: begin
            if (accept) begin
               mcand_d  = A;
               mplier_d = B;
               acc_d    = '0;
               count_d  = '0;
               state_d  = StRun;
            end else begin
               state_d  = StIdle;
            end
         end
         StRun: begin
            acc_d    = sum[WIDTH:1];
            mplier_d = {sum[0], mplier_q[WIDTH-1:1]};
            count_d  = count_q + CntW'(1);
            if (count_q == LastCnt) begin
               prod_hi_d = sum[WIDTH:1];
               prod_lo_d = {sum[0], mplier_q[WIDTH-1:1]};
               state_d   = StDone;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         mcand_q   <= '0;
         mplier_q  <= '0;
         acc_q     <= '0;
         count_q   <= '0;
         prod_lo_q <= '0;
         prod_hi_q <= '0;
      end else begin
         state_q   <= state_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         acc_q     <= acc_d;
         count_q   <= count_d;
         prod_lo_q <= prod_lo_d;
         prod_hi_q <= prod_hi_d;
      end
   end

   assign busy         = (state_q == StRun);
   assign done         = (state_q == StDone);
   assign product_low  = prod_lo_q;
   assign product_high = prod_hi_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: directed cases plus random operands
// against A*B, on a 4-bit and an 8-bit instance.
module tb_seq_multiplier;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start4, start8;
   logic [3:0] a4, b4;
   logic [7:0] a8, b8;
   logic       busy4, done4, busy8, done8;
   logic [3:0] pl4, ph4;
   logic [7:0] pl8, ph8;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   seq_multiplier #(.WIDTH(4)) u_dut4 (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start4),
      .A            (a4),
      .B            (b4),
      .busy         (busy4),
      .done         (done4),
      .product_low  (pl4),
      .product_high (ph4)
   );

   seq_multiplier #(.WIDTH(8)) u_dut8 (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start8),
      .A            (a8),
      .B            (b8),
      .busy         (busy8),
      .done         (done8),
      .product_low  (pl8),
      .product_high (ph8)
   );

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] get_prod(input bit w8);
      return w8 ? {ph8, pl8} : {8'h00, ph4, pl4};
   endfunction

   function automatic logic get_busy(input bit w8);
      return w8 ? busy8 : busy4;
   endfunction

   function automatic logic get_done(input bit w8);
      return w8 ? done8 : done4;
   endfunction

   task automatic set_in(input bit w8, input logic s, input logic [7:0] a, input logic [7:0] b);
      if (w8) begin
         start8 = s; a8 = a; b8 = b;
      end else begin
         start4 = s; a4 = a[3:0]; b4 = b[3:0];
      end
   endtask

   // One operation: start pulse, WIDTH busy cycles, one done cycle, then idle.
   // With poke set, start is re-asserted with fresh operands throughout RUN.
   task automatic op(input string tag, input bit w8, input logic [7:0] a, input logic [7:0] b,
                     input bit poke);
      int          w;
      int unsigned am, bm;
      logic [15:0] exp, prev;
      w    = w8 ? 8 : 4;
      am   = w8 ? a : (a & 8'h0f);
      bm   = w8 ? b : (b & 8'h0f);
      exp  = 16'(am * bm);
      prev = get_prod(w8);
      @(negedge clk);
      set_in(w8, 1'b1, a, b);
      for (int i = 0; i < w; i++) begin
         @(negedge clk);
         check({tag, " busy"}, 16'(get_busy(w8)), 16'd1);
         check({tag, " done early"}, 16'(get_done(w8)), 16'd0);
         check({tag, " prod hold"}, get_prod(w8), prev);
         set_in(w8, poke, 8'($urandom), 8'($urandom));
      end
      @(negedge clk);
      check({tag, " busy end"}, 16'(get_busy(w8)), 16'd0);
      check({tag, " done"}, 16'(get_done(w8)), 16'd1);
      check({tag, " prod"}, get_prod(w8), exp);
      set_in(w8, 1'b0, 8'($urandom), 8'($urandom));
      @(negedge clk);
      check({tag, " done pulse"}, 16'(get_done(w8)), 16'd0);
      check({tag, " idle busy"}, 16'(get_busy(w8)), 16'd0);
      check({tag, " prod kept"}, get_prod(w8), exp);
   endtask

   initial begin
      rst_n = 1'b0;
      set_in(1'b0, 1'b0, 8'h00, 8'h00);
      set_in(1'b1, 1'b0, 8'h00, 8'h00);
      repeat (3) @(negedge clk);
      check("rst busy4", 16'(busy4), 16'd0);
      check("rst done4", 16'(done4), 16'd0);
      check("rst prod4", get_prod(1'b0), 16'd0);
      check("rst busy8", 16'(busy8), 16'd0);
      check("rst prod8", get_prod(1'b1), 16'd0);
      rst_n = 1'b1;
      @(negedge clk);

      op("t1 2x3", 1'b0, 8'h2, 8'h3, 1'b0);
      op("t2 15x15", 1'b0, 8'hf, 8'hf, 1'b0);
      op("t2 0x11", 1'b0, 8'h0, 8'hb, 1'b0);
      op("t3 5x5 poked", 1'b0, 8'h5, 8'h5, 1'b1);

      // Reset in the second RUN cycle aborts with no done pulse
      @(negedge clk);
      set_in(1'b0, 1'b1, 8'h6, 8'h3);
      @(negedge clk);
      check("t4 busy", 16'(busy4), 16'd1);
      set_in(1'b0, 1'b0, 8'h0, 8'h0);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("t4 busy rst", 16'(busy4), 16'd0);
      check("t4 done rst", 16'(done4), 16'd0);
      check("t4 prod rst", get_prod(1'b0), 16'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("t4 no done", 16'(done4), 16'd0);
         check("t4 no busy", 16'(busy4), 16'd0);
      end

      // Reset beats a simultaneous start
      rst_n = 1'b0;
      set_in(1'b0, 1'b1, 8'h7, 8'h7);
      @(negedge clk);
      rst_n = 1'b1;
      set_in(1'b0, 1'b0, 8'h0, 8'h0);
      @(negedge clk);
      check("rst+start busy", 16'(busy4), 16'd0);
      check("rst+start done", 16'(done4), 16'd0);

      // Start held high: back-to-back operations, done every WIDTH+1 cycles
      set_in(1'b0, 1'b1, 8'h9, 8'h4);
      for (int k = 0; k < 15; k++) begin
         @(negedge clk);
         check("t5 busy", 16'(busy4), ((k % 5) < 4) ? 16'd1 : 16'd0);
         check("t5 done", 16'(done4), ((k % 5) == 4) ? 16'd1 : 16'd0);
         if ((k % 5) == 4) check("t5 prod", get_prod(1'b0), 16'd36);
         if (k == 14) set_in(1'b0, 1'b0, 8'h9, 8'h4);
      end
      @(negedge clk);
      check("t5 stop busy", 16'(busy4), 16'd0);
      check("t5 stop done", 16'(done4), 16'd0);

      op("t6 ffxff", 1'b1, 8'hff, 8'hff, 1'b0);
      for (int i = 0; i < 12; i++) begin
         op("rnd4", 1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
         op("rnd8", 1'b1, 8'($urandom), 8'($urandom), 1'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
